// File: rtl/f_adder_back.sv
// Back end of the double-precision adder: sign/magnitude, leading-zero normalise,
// round-to-nearest-even and IEEE-754 pack with exception flags, as a 3-stage pipeline.
module f_adder_back #(
  parameter int info_width = 1,
  parameter int exp_width  = 11,
  parameter int frac_width = 52
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            a_wait,
  input  logic                            flush,
  output logic                            busy,
  input  logic [exp_width+1:0]            in_exp,
  input  logic [2*frac_width+3:0]         in_frac,
  input  logic                            in_invalid,
  input  logic                            in_inf,
  input  logic                            in_inf_sign,
  input  logic [info_width-1:0]           info_in,
  output logic [exp_width+frac_width:0]   result,
  output logic [info_width-1:0]           info_out,
  output logic                            f_invalid,
  output logic                            f_overflow,
  output logic                            f_underflow,
  output logic                            f_inexact
);
  localparam int LFW  = 2*frac_width + 4;
  localparam int MAGW = LFW - 1;
  localparam int EW   = exp_width + 2;
  localparam int ENW  = exp_width + 3;
  localparam int LZW  = $clog2(MAGW + 1);
  localparam int GPOS = MAGW - 2 - frac_width;
  localparam int RW   = exp_width + frac_width + 1;
  localparam logic signed [ENW-1:0] EXP_MAX  = ENW'((1 << exp_width) - 1);
  localparam logic signed [ENW-1:0] EXP_ZERO = '0;
  localparam logic [RW-1:0] QNAN = {1'b0, {exp_width{1'b1}}, 1'b1, {(frac_width-1){1'b0}}};

  function automatic logic [LZW-1:0] lzc(input logic [MAGW-1:0] v);
    lzc = LZW'(MAGW);
    for (int i = 0; i < MAGW; i++)
      if (v[i]) lzc = LZW'(MAGW - 1 - i);
  endfunction

  // Carry out lands in the top bit; the caller bumps the exponent with it.
  function automatic logic [frac_width:0] rne(input logic [frac_width-1:0] m,
                                              input logic g, input logic s);
    rne = {1'b0, m} + {{frac_width{1'b0}}, g & (s | m[0])};
  endfunction

  function automatic logic [RW+3:0] pack(input logic inv, input logic inf, input logic infs,
                                         input logic zero, input logic sign,
                                         input logic signed [ENW-1:0] e,
                                         input logic [frac_width-1:0] f, input logic inx);
    if (inv)                pack = {QNAN, 4'b1000};
    else if (inf)           pack = {infs, {exp_width{1'b1}}, {frac_width{1'b0}}, 4'b0000};
    else if (zero)          pack = '0;
    else if (e >= EXP_MAX)  pack = {sign, {exp_width{1'b1}}, {frac_width{1'b0}}, 4'b0101};
    else if (e <= EXP_ZERO) pack = {sign, {(RW-1){1'b0}}, 4'b0011};
    else                    pack = {sign, e[exp_width-1:0], f, 3'b000, inx};
  endfunction

  logic                   sign_p0_q, inv_p0_q, inf_p0_q, infs_p0_q;
  logic [MAGW-1:0]        mag_p0_q;
  logic signed [EW-1:0]   exp_p0_q;
  logic [info_width-1:0]  info_p0_q, info_p0_d;
  logic                   sign_p1_q, inv_p1_q, inf_p1_q, infs_p1_q;
  logic [MAGW-1:0]        norm_p1_q, norm_p1_d;
  logic signed [ENW-1:0]  expn_p1_q, expn_p1_d;
  logic [info_width-1:0]  info_p1_q, info_p1_d;
  logic [info_width-1:0]  info_out_d;

  assign busy = a_wait;

  // S1: sign and magnitude (|value| < 4, so the low bits suffice for negation)
  logic            sign_p0_d;
  logic [MAGW-1:0] mag_p0_d;
  assign sign_p0_d = in_frac[LFW-1];
  assign mag_p0_d  = sign_p0_d ? (~in_frac[MAGW-1:0] + MAGW'(1)) : in_frac[MAGW-1:0];

  // S2: normalise so the hidden bit sits at the top of norm
  logic [LZW-1:0] lz_p1;
  assign lz_p1     = lzc(mag_p0_q);
  assign norm_p1_d = mag_p0_q << lz_p1;
  assign expn_p1_d = $signed({exp_p0_q[EW-1], exp_p0_q} + ENW'(1)
                             - {{(ENW-LZW){1'b0}}, lz_p1});

  // S3: round and pack; a clear hidden bit means the magnitude was zero
  logic [frac_width-1:0] m_p2;
  logic                  g_p2, s_p2;
  logic [frac_width:0]   rnd_p2;
  logic signed [ENW-1:0] expr_p2;
  logic [RW+3:0]         pk_p2;
  assign m_p2    = norm_p1_q[MAGW-2 -: frac_width];
  assign g_p2    = norm_p1_q[GPOS];
  assign s_p2    = |norm_p1_q[GPOS-1:0];
  assign rnd_p2  = rne(m_p2, g_p2, s_p2);
  assign expr_p2 = expn_p1_q + $signed({{(ENW-1){1'b0}}, rnd_p2[frac_width]});
  assign pk_p2   = pack(inv_p1_q, inf_p1_q, infs_p1_q, ~norm_p1_q[MAGW-1], sign_p1_q,
                        expr_p2, rnd_p2[frac_width-1:0], g_p2 | s_p2);

  // Flush clears the valid bit even while stalled.
  always_comb begin
    info_p0_d  = a_wait ? info_p0_q : info_in;
    info_p1_d  = a_wait ? info_p1_q : info_p0_q;
    info_out_d = a_wait ? info_out  : info_p1_q;
    if (flush) begin
      info_p0_d[0]  = 1'b0;
      info_p1_d[0]  = 1'b0;
      info_out_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_p0_q <= 1'b0; mag_p0_q <= '0; exp_p0_q <= '0;
      inv_p0_q  <= 1'b0; inf_p0_q <= 1'b0; infs_p0_q <= 1'b0; info_p0_q <= '0;
      sign_p1_q <= 1'b0; norm_p1_q <= '0; expn_p1_q <= '0;
      inv_p1_q  <= 1'b0; inf_p1_q <= 1'b0; infs_p1_q <= 1'b0; info_p1_q <= '0;
      result    <= '0; info_out <= '0;
      f_invalid <= 1'b0; f_overflow <= 1'b0; f_underflow <= 1'b0; f_inexact <= 1'b0;
    end else begin
      info_p0_q <= info_p0_d;
      info_p1_q <= info_p1_d;
      info_out  <= info_out_d;
      if (!a_wait) begin
        sign_p0_q <= sign_p0_d;
        mag_p0_q  <= mag_p0_d;
        exp_p0_q  <= in_exp;
        inv_p0_q  <= in_invalid;
        inf_p0_q  <= in_inf;
        infs_p0_q <= in_inf_sign;
        sign_p1_q <= sign_p0_q;
        norm_p1_q <= norm_p1_d;
        expn_p1_q <= expn_p1_d;
        inv_p1_q  <= inv_p0_q;
        inf_p1_q  <= inf_p0_q;
        infs_p1_q <= infs_p0_q;
        {result, f_invalid, f_overflow, f_underflow, f_inexact} <= pk_p2;
      end
    end
  end
endmodule

// File: tb/tb_f_adder_back.sv
// Scoreboard bench for f_adder_back: directed and random stimulus against a
// value-level rounding model, plus stall, flush and mid-stream reset scenarios.
module tb_f_adder_back;
  logic         clk = 1'b0;
  logic         resetn, a_wait, flush, busy;
  logic [12:0]  in_exp;
  logic [107:0] in_frac;
  logic         in_invalid, in_inf, in_inf_sign;
  logic [0:0]   info_in, info_out;
  logic [63:0]  result;
  logic         f_invalid, f_overflow, f_underflow, f_inexact;

  f_adder_back #(.info_width(1), .exp_width(11), .frac_width(52)) dut (
    .clk(clk), .resetn(resetn), .a_wait(a_wait), .flush(flush), .busy(busy),
    .in_exp(in_exp), .in_frac(in_frac), .in_invalid(in_invalid), .in_inf(in_inf),
    .in_inf_sign(in_inf_sign), .info_in(info_in), .result(result), .info_out(info_out),
    .f_invalid(f_invalid), .f_overflow(f_overflow), .f_underflow(f_underflow),
    .f_inexact(f_inexact));

  always #5 clk = ~clk;

  typedef struct packed { logic [63:0] res; logic [3:0] flg; } exp_t;
  exp_t sb[$];
  exp_t fq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t last_e;
  bit   last_v, last_known;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Value-level reference: locate the top set bit, keep 52 bits below it and
  // round the discarded remainder against one half ulp.
  function automatic exp_t model(input logic [107:0] f, input logic [12:0] e,
                                 input logic inv, input logic inf, input logic infs);
    exp_t r; logic sgn; logic [107:0] a; logic [127:0] mag, rem, half;
    logic [53:0] mm; int p, sh, E; logic inx;
    if (inv) return '{64'h7FF8000000000000, 4'b1000};
    if (inf) return '{{infs, 11'h7FF, 52'd0}, 4'b0000};
    sgn = f[107];
    a   = sgn ? (~f + 108'd1) : f;
    mag = {20'd0, a};
    if (mag == 0) return '{64'd0, 4'b0000};
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    E = int'($signed(e)) + p - 105;
    inx = 1'b0;
    if (p > 52) begin
      sh   = p - 52;
      mm   = 54'(mag >> sh);
      rem  = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && mm[0])) mm = mm + 54'd1;
    end else begin
      mm = 54'(mag << (52 - p));
    end
    if (mm[53]) begin E = E + 1; mm = '0; end
    if (E >= 2047)   r = '{{sgn, 11'h7FF, 52'd0}, 4'b0101};
    else if (E <= 0) r = '{{sgn, 63'd0}, 4'b0011};
    else             r = '{{sgn, 11'(E), mm[51:0]}, {3'b000, inx}};
    return r;
  endfunction

  task automatic put(input logic [107:0] f, input logic [12:0] e, input logic inv,
                     input logic inf, input logic infs, input logic v, input logic aw,
                     input bit use_m, input exp_t x);
    in_frac = f; in_exp = e; in_invalid = inv; in_inf = inf; in_inf_sign = infs;
    info_in = v; a_wait = aw; flush = 1'b0;
    if (v && !aw) sb.push_back(use_m ? model(f, e, inv, inf, infs) : x);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put('0, '0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic rnd_one(input bit force_v, input bit allow_stall);
    logic [127:0] w; logic [107:0] m; logic [12:0] e; int t;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    m = {1'b0, w[106:0]} >> $urandom_range(0, 110);
    if ($urandom_range(0, 3) == 0) m[59:0] = {1'b1, 59'd0} >> $urandom_range(0, 20);
    if ($urandom_range(0, 1) == 1) m = ~m + 108'd1;
    case ($urandom_range(0, 5))
      0: e = 13'($urandom_range(1010, 1036));
      1: e = 13'($urandom_range(2030, 2100));
      2: e = 13'($urandom_range(0, 130));
      3: begin t = int'($urandom_range(1, 300)); e = 13'(-t); end
      default: e = 13'($urandom_range(1, 2046));
    endcase
    put(m, e, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, 1'($urandom),
        force_v || ($urandom_range(0, 7) != 0),
        allow_stall && ($urandom_range(0, 4) == 0), 1, '0);
  endtask

  // Monitor: a new output appears after every edge taken with a_wait low.
  initial begin
    bit aw, rs; exp_t e;
    last_known = 0;
    forever begin
      @(posedge clk);
      aw = a_wait; rs = resetn;
      #1;
      if (rs && resetn) begin
        if (aw) begin
          if (last_known) begin
            chk("stall_result", result, last_e.res);
            chk("stall_valid", 64'(info_out[0]), 64'(last_v));
          end
        end else if (info_out[0]) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: actual=%h required=none", result);
            last_known = 0;
          end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("flags", 64'({f_invalid, f_overflow, f_underflow, f_inexact}), 64'(e.flg));
            last_e = e; last_v = 1; last_known = 1;
          end
        end else if (fq.size() > 0) begin
          e = fq.pop_front();
          chk("flushed_result", result, e.res);
          chk("flushed_flags", 64'({f_invalid, f_overflow, f_underflow, f_inexact}), 64'(e.flg));
          last_e = e; last_v = 0; last_known = 1;
        end else begin
          last_known = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; a_wait = 1'b0; flush = 1'b0; in_exp = '0; in_frac = '0;
    in_invalid = 1'b0; in_inf = 1'b0; in_inf_sign = 1'b0; info_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", result, 64'd0);
    chk("reset_info", 64'(info_out), 64'd0);
    chk("reset_flags", 64'({f_invalid, f_overflow, f_underflow, f_inexact}), 64'd0);
    a_wait = 1'b1; #1;
    chk("busy_high", 64'(busy), 64'd1);
    a_wait = 1'b0; #1;
    chk("busy_low", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    put(108'd1 << 105, 13'd1023, 0, 0, 0, 1, 0, 0, '{64'h3FF0000000000000, 4'b0000});
    put(-(108'd3 << 104), 13'd1023, 0, 0, 0, 1, 0, 0, '{64'hBFF8000000000000, 4'b0000});
    put((108'd1 << 105) | (108'd1 << 52), 13'd1023, 0, 0, 0, 1, 0, 0,
        '{64'h3FF0000000000000, 4'b0001});
    put((108'd1 << 105) | (108'd1 << 53) | (108'd1 << 52), 13'd1023, 0, 0, 0, 1, 0, 0,
        '{64'h3FF0000000000002, 4'b0001});
    put(108'd1 << 106, 13'd2046, 0, 0, 0, 1, 0, 0, '{64'h7FF0000000000000, 4'b0101});
    put(108'd1 << 105, 13'd1023, 1, 0, 0, 1, 0, 0, '{64'h7FF8000000000000, 4'b1000});
    put(108'd0, 13'd1023, 0, 0, 0, 1, 0, 0, '{64'h0000000000000000, 4'b0000});
    put(108'd0, 13'd1023, 0, 1, 1, 1, 0, 0, '{64'hFFF0000000000000, 4'b0000});
    put(-(108'd1 << 105), 13'd0, 0, 0, 0, 1, 0, 0, '{64'h8000000000000000, 4'b0011});
    idle(4);

    for (int i = 0; i < 4; i++) rnd_one(1, 0);
    for (int i = 0; i < 3; i++) put('0, '0, 0, 0, 0, 0, 1, 0, '0);
    idle(5);

    for (int i = 0; i < 4; i++) rnd_one(1, 0);
    while (sb.size() > 0) fq.push_back(sb.pop_front());
    info_in = 1'b0; a_wait = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(5);
    chk("flush_drained", 64'(fq.size()), 64'd0);

    for (int i = 0; i < 400; i++) rnd_one(0, 1);
    idle(6);

    for (int i = 0; i < 3; i++) rnd_one(1, 0);
    #2 resetn = 1'b0;
    #1;
    chk("midreset_result", result, 64'd0);
    chk("midreset_info", 64'(info_out), 64'd0);
    chk("midreset_flags", 64'({f_invalid, f_overflow, f_underflow, f_inexact}), 64'd0);
    sb.delete(); fq.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(4);
    for (int i = 0; i < 20; i++) rnd_one(0, 1);
    idle(6);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
